blockmix_ctrl: RTL and testbench

Sequencer that runs scrypt BlockMix_salsa20/8 with r=1 on a 1024-bit block by driving an external `salsa20_8` core through its `enable`/`hash_done` handshake. It builds each 512-bit core input (X xor B_i), launches the core, captures its results, and assembles the mixed 1024-bit output. It sits between the ROMix memory stage and one shared `salsa20_8` instance, and owns that instance's input side.

---
 rtl/blockmix_ctrl.sv | 120 ++++++++++++
 tb/tb_blockmix_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blockmix_ctrl.sv
// blockmix_ctrl: scrypt BlockMix_salsa20/8 (r=1) sequencer.
// Drives one shared salsa20_8 core through enable/hash_done.
module blockmix_ctrl #(
  parameter int TIMEOUT = 40
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          start,
  input  logic [1023:0] data_in,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [1023:0] data_out,
  output logic [511:0]  salsa_data,
  output logic          salsa_enable,
  input  logic [511:0]  salsa_data_out,
  input  logic          salsa_done
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD0,
    S_WAIT0,
    S_LOAD1,
    S_WAIT1,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [511:0]    b1_q, b1_d;
  logic [511:0]    sdata_q, sdata_d;
  logic [1023:0]   dout_q, dout_d;
  logic            err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Next-state, datapath and timeout-counter update.
  // The counter counts cycles since launch, the LOAD cycle included,
  // so the timeout lands TIMEOUT cycles after the launch strobe.
  always_comb begin
    state_d = state_q;
    b1_d    = b1_q;
    sdata_d = sdata_q;
    dout_d  = dout_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          b1_d    = data_in[511:0];
          sdata_d = data_in[1023:512] ^ data_in[511:0];
          err_d   = 1'b0;
          state_d = S_LOAD0;
        end
      end
      S_LOAD0: begin
        cnt_d   = CW'(1);
        state_d = S_WAIT0;
      end
      S_LOAD1: begin
        cnt_d   = CW'(1);
        state_d = S_WAIT1;
      end
      S_WAIT0, S_WAIT1: begin
        if (salsa_done) begin
          if (state_q == S_WAIT0) begin
            dout_d[1023:512] = salsa_data_out;
            sdata_d          = salsa_data_out ^ b1_q;
            state_d          = S_LOAD1;
          end else begin
            dout_d[511:0] = salsa_data_out;
            state_d       = S_DONE;
          end
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      b1_q    <= '0;
      sdata_q <= '0;
      dout_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      b1_q    <= b1_d;
      sdata_q <= sdata_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign salsa_enable = (state_q == S_LOAD0) ||
                        (state_q == S_LOAD1);
  assign error        = err_q;
  assign data_out     = dout_q;
  assign salsa_data   = sdata_q;

endmodule

// File: tb/tb_blockmix_ctrl.sv
// tb_blockmix_ctrl: scoreboard bench with a mock salsa20_8
// core (echo ^ key, programmable latency).
module tb_blockmix_ctrl;

  localparam int TO = 40;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          start = 1'b0;
  logic [1023:0] data_in = '0;
  logic          busy, done, error, salsa_enable;
  logic [1023:0] data_out;
  logic [511:0]  salsa_data;
  logic [511:0]  salsa_data_out;
  logic          salsa_done, mock_done;
  logic          spur_done = 1'b0;

  blockmix_ctrl #(.TIMEOUT(TO)) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .start          (start),
    .data_in        (data_in),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .data_out       (data_out),
    .salsa_data     (salsa_data),
    .salsa_enable   (salsa_enable),
    .salsa_data_out (salsa_data_out),
    .salsa_done     (salsa_done)
  );

  always #5 clk = ~clk;

  assign salsa_done = mock_done | spur_done;

  // mock core: hash_done comes mock_lat cycles after the enable cycle
  int           mock_lat = 5;
  bit           mock_on = 1'b1;
  logic [511:0] mock_key = '0;
  logic [511:0] mock_buf;
  int           mcnt;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mcnt           <= 0;
      mock_done      <= 1'b0;
      salsa_data_out <= '0;
      mock_buf       <= '0;
    end else begin
      mock_done <= 1'b0;
      if (salsa_enable && mock_on) begin
        mcnt     <= mock_lat - 1;
        mock_buf <= salsa_data;
      end else if (mcnt == 1) begin
        mcnt           <= 0;
        mock_done      <= 1'b1;
        salsa_data_out <= mock_buf ^ mock_key;
      end else if (mcnt > 1) begin
        mcnt <= mcnt - 1;
      end
    end
  end

  int cyc = 0;
  int t0 = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [511:0] d;
    int           c;
  } launch_t;
  typedef struct {
    logic [1023:0] d;
    int            c;
  } res_t;

  launch_t lq[$];
  res_t    rq[$];
  launch_t le;
  res_t    re;

  int errors = 0;
  int checks = 0;
  int ndone = 0;
  int nbusy = 0;

  task automatic chk(input string nm,
                     input logic [511:0] act,
                     input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor: pops the scoreboard whenever the DUT launches or finishes
  always @(negedge clk) begin
    if (n_rst) begin
      if (busy) nbusy++;
      if (salsa_enable) begin
        if (lq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL launch: unexpected enable at rel cycle %0d",
                   cyc - t0);
        end else begin
          le = lq.pop_front();
          chk("launch_data", salsa_data, le.d);
          chk("launch_cycle", 512'(cyc - t0), 512'(le.c));
        end
      end
      if (done) begin
        ndone++;
        if (rq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done: unexpected done at rel cycle %0d",
                   cyc - t0);
        end else begin
          re = rq.pop_front();
          chk("result_hi", data_out[1023:512], re.d[1023:512]);
          chk("result_lo", data_out[511:0], re.d[511:0]);
          chk("done_cycle", 512'(cyc - t0), 512'(re.c));
        end
      end
    end
  end

  task automatic push_l(input logic [511:0] d, input int c);
    launch_t x;
    x.d = d;
    x.c = c;
    lq.push_back(x);
  endtask

  task automatic push_r(input logic [1023:0] d, input int c);
    res_t x;
    x.d = d;
    x.c = c;
    rq.push_back(x);
  endtask

  task automatic pulse_start(input logic [1023:0] d);
    @(negedge clk);
    data_in = d;
    start   = 1'b1;
    t0      = cyc;
    nbusy   = 0;
    @(negedge clk);
    start   = 1'b0;
    data_in = ~d;
  endtask

  task automatic wait_done(input int n, input int bound);
    int k = 0;
    while (ndone < n && k < bound) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (ndone < n) begin
      errors++;
      $display("FAIL wait_done: done count %0d required %0d", ndone, n);
    end
  endtask

  logic [511:0] A5, C3, N9, P, Q, K, X88, X77, XFE, F0, OF, ONE;
  logic [1023:0] keep;
  int nd0;

  initial begin
    A5  = {16{32'hA5A5A5A5}};
    C3  = {16{32'h3C3C3C3C}};
    N9  = {16{32'h99999999}};
    P   = {16{32'h01234567}};
    Q   = {16{32'h89ABCDEF}};
    K   = {16{32'hFFFFFFFF}};
    X88 = {16{32'h88888888}};
    X77 = {16{32'h77777777}};
    XFE = {16{32'hFEDCBA98}};
    F0  = {16{32'hF0F0F0F0}};
    OF  = {16{32'h0F0F0F0F}};
    ONE = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_enable", salsa_enable, 0);
    chk("rst_dout_hi", data_out[1023:512], 0);
    chk("rst_dout_lo", data_out[511:0], 0);
    chk("rst_sdata", salsa_data, 0);
    n_rst = 1'b1;

    // mock echo, latency 5: B0 all-A5, B1 all-3C
    mock_lat = 5;
    mock_key = '0;
    push_l(N9, 1);
    push_l(A5, 7);
    push_r({N9, A5}, 13);
    pulse_start({A5, C3});
    wait_done(1, 100);
    repeat (3) @(negedge clk);
    chk("echo_busy_cycles", 512'(nbusy), 512'(13));
    chk("echo_error", error, 0);

    // core-like latency 34, keyed mock
    mock_lat = 34;
    mock_key = K;
    push_l(X88, 1);
    push_l(XFE, 36);
    push_r({X77, P}, 71);
    pulse_start({P, Q});
    wait_done(2, 200);
    repeat (3) @(negedge clk);
    chk("t34_busy_cycles", 512'(nbusy), 512'(71));

    // spurious done in IDLE, start pulse in WAIT0
    keep = data_out;
    @(negedge clk);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("spur_keep_hi", data_out[1023:512], keep[1023:512]);
    chk("spur_keep_lo", data_out[511:0], keep[511:0]);
    chk("spur_busy", busy, 0);
    mock_lat = 5;
    nd0 = ndone;
    push_l(K, 1);
    push_l(OF, 7);
    push_r({ONE, F0}, 13);
    pulse_start({F0, OF});
    @(negedge clk);
    @(negedge clk);
    data_in = {Q, P};
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    wait_done(nd0 + 1, 100);
    repeat (20) @(negedge clk);
    chk("ign_one_done", 512'(ndone - nd0), 512'(1));

    // start held high: back-to-back runs
    mock_key = '0;
    nd0 = ndone;
    push_l(N9, 1);
    push_l(A5, 7);
    push_l(N9, 15);
    push_l(A5, 21);
    push_r({N9, A5}, 13);
    push_r({N9, A5}, 27);
    @(negedge clk);
    data_in = {A5, C3};
    start   = 1'b1;
    t0      = cyc;
    repeat (20) @(negedge clk);
    start = 1'b0;
    wait_done(nd0 + 2, 100);
    repeat (3) @(negedge clk);

    // timeout: mock never answers
    mock_on = 1'b0;
    push_l(X88, 1);
    pulse_start({P, Q});
    repeat (39) @(negedge clk);
    chk("to_err_pre", error, 0);
    chk("to_busy_pre", busy, 1);
    @(negedge clk);
    chk("to_err", error, 1);
    chk("to_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("to_sticky", error, 1);
    mock_on = 1'b1;
    nd0 = ndone;
    push_l(N9, 1);
    push_l(A5, 7);
    push_r({N9, A5}, 13);
    pulse_start({A5, C3});
    chk("to_clear", error, 0);
    wait_done(nd0 + 1, 100);
    repeat (3) @(negedge clk);

    // asynchronous reset during WAIT1
    mock_lat = 34;
    mock_key = K;
    push_l(X88, 1);
    push_l(XFE, 36);
    push_r({X77, P}, 71);
    pulse_start({P, Q});
    repeat (49) @(negedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_done", done, 0);
    chk("ar_enable", salsa_enable, 0);
    chk("ar_dout_hi", data_out[1023:512], 0);
    chk("ar_dout_lo", data_out[511:0], 0);
    chk("ar_sdata", salsa_data, 0);
    chk("ar_pending", 512'(lq.size()), 0);
    rq.delete();
    @(negedge clk);
    n_rst = 1'b1;
    nd0 = ndone;
    push_l(X88, 1);
    push_l(XFE, 36);
    push_r({X77, P}, 71);
    pulse_start({P, Q});
    wait_done(nd0 + 1, 200);
    repeat (5) @(negedge clk);

    chk("sb_launch_empty", 512'(lq.size()), 0);
    chk("sb_result_empty", 512'(rq.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
